// File: rtl/color_classifier.sv
// Per-frame RGB332 colour classifier: counts red/green/blue pixels and picks the dominant one.
// Define COLOR_CLASSIFIER_WINDOW_EN to count only the central 80x60 window.
module color_classifier #(
  parameter int AW      = 15,
  parameter int NPIX    = 19200,
  parameter int HRES    = 160,
  parameter int MIN_CNT = 1000
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          px_wr,
  input  logic [7:0]    mem_px_data,
  input  logic [AW-1:0] mem_px_addr,
  output logic [AW-1:0] red_cnt,
  output logic [AW-1:0] green_cnt,
  output logic [AW-1:0] blue_cnt,
  output logic [1:0]    color,
  output logic          done
);

  localparam int XW = (HRES > 1) ? $clog2(HRES) : 1;
  localparam logic [AW-1:0] NPIX_W = AW'(NPIX);
  localparam logic [AW-1:0] MIN_W  = AW'(MIN_CNT);
  localparam logic [XW-1:0] XLAST  = XW'(HRES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DECIDE,
    S_HOLD
  } state_t;

  state_t        r_state, w_next;
  logic          r_vsync;
  logic          r_armed;
  logic [AW-1:0] r_pcnt;
  logic [AW-1:0] r_racc, r_gacc, r_bacc;
  logic [XW-1:0] r_x;
  logic [AW-1:0] r_y;

  logic          w_vs_fall, w_vs_rise;
  logic          w_pix, w_last, w_elig;
  logic [AW-1:0] w_pcnt_nx;
  logic [2:0]    w_r, w_g;
  logic [1:0]    w_b;
  logic          w_is_red, w_is_green, w_is_blue;
  logic [1:0]    w_color;
  logic          w_unused;

  // A fall only counts once vsync has been seen high after reset,
  // so a frame already running at reset release is skipped.
  assign w_vs_fall = r_armed & r_vsync & ~vsync;
  assign w_vs_rise = ~r_vsync & vsync;

  assign w_pix     = (r_state == S_ACCUM) & px_wr;
  assign w_pcnt_nx = r_pcnt + AW'(1);
  assign w_last    = w_pix & (w_pcnt_nx == NPIX_W);

  assign w_r = mem_px_data[7:5];
  assign w_g = mem_px_data[4:2];
  assign w_b = mem_px_data[1:0];

  assign w_is_red   = (w_r >= 3'd5) & (w_g <= 3'd3) & (w_b <= 2'd1);
  assign w_is_green = (w_g >= 3'd5) & (w_r <= 3'd3) & (w_b <= 2'd1);
  assign w_is_blue  = (w_b >= 2'd2) & (w_r <= 3'd3) & (w_g <= 3'd3);

`ifdef COLOR_CLASSIFIER_WINDOW_EN
  assign w_elig = (r_x >= XW'(40)) & (r_x <= XW'(119)) &
                  (r_y >= AW'(30)) & (r_y <= AW'(89));
`else
  assign w_elig = 1'b1;
`endif

  assign w_unused = ^mem_px_addr;

  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
    return (v == NPIX_W) ? v : v + AW'(1);
  endfunction

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_vs_fall) w_next = S_ACCUM;
      S_ACCUM:  if (w_vs_rise | w_last) w_next = S_DECIDE;
      S_DECIDE: w_next = S_HOLD;
      S_HOLD:   if (vsync) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Strictly largest count wins; any tie for the top leaves colour at 0.
  always_comb begin
    w_color = 2'd0;
    if ((r_racc > r_gacc) && (r_racc > r_bacc) && (r_racc >= MIN_W))
      w_color = 2'd1;
    else if ((r_gacc > r_racc) && (r_gacc > r_bacc) && (r_gacc >= MIN_W))
      w_color = 2'd2;
    else if ((r_bacc > r_racc) && (r_bacc > r_gacc) && (r_bacc >= MIN_W))
      w_color = 2'd3;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vsync <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_next;
      r_vsync <= vsync;
      r_armed <= r_armed | vsync;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_pcnt    <= '0;
      r_racc    <= '0;
      r_gacc    <= '0;
      r_bacc    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      red_cnt   <= '0;
      green_cnt <= '0;
      blue_cnt  <= '0;
      color     <= 2'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_pcnt <= '0;
        r_racc <= '0;
        r_gacc <= '0;
        r_bacc <= '0;
        r_x    <= '0;
        r_y    <= '0;
      end else if (w_pix) begin
        r_pcnt <= w_pcnt_nx;
        if (r_x == XLAST) begin
          r_x <= '0;
          r_y <= r_y + AW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
        if (w_elig & w_is_red)   r_racc <= sat_inc(r_racc);
        if (w_elig & w_is_green) r_gacc <= sat_inc(r_gacc);
        if (w_elig & w_is_blue)  r_bacc <= sat_inc(r_bacc);
      end
      if (r_state == S_DECIDE) begin
        red_cnt   <= r_racc;
        green_cnt <= r_gacc;
        blue_cnt  <= r_bacc;
        color     <= w_color;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_color_classifier.sv
// Bench for color_classifier: table-driven frames with a done-triggered scoreboard,
// plus hand sequences for classification edges, ignored strobes and mid-frame reset.
module tb_color_classifier;

  localparam int AW = 15;

  logic          pclk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync = 1'b1;
  logic          px_wr = 1'b0;
  logic [7:0]    mem_px_data = '0;
  logic [AW-1:0] mem_px_addr = '0;
  logic [AW-1:0] red_cnt, green_cnt, blue_cnt;
  logic [1:0]    color;
  logic          done;

  int    checks = 0;
  int    errors = 0;
  int    addr = 0;
  int    n_done = 0;
  string cur = "reset";

  typedef struct {
    logic [AW-1:0] r;
    logic [AW-1:0] g;
    logic [AW-1:0] b;
    logic [1:0]    c;
  } exp_t;

  typedef struct {
    int         n0;
    logic [7:0] p0;
    int         n1;
    logic [7:0] p1;
    int         n2;
    logic [7:0] p2;
    bit         vend;
    int         er;
    int         eg;
    int         eb;
    int         ec;
  } frame_t;

  typedef struct {
    logic [7:0] p;
    int         cls;
    int         n;
  } mix_t;

  exp_t   sb[$];
  exp_t   m_e;
  frame_t tbl[7];
  frame_t fb;
  mix_t   mix[12];

  color_classifier dut (
    .pclk       (pclk),
    .rst        (rst),
    .vsync      (vsync),
    .px_wr      (px_wr),
    .mem_px_data(mem_px_data),
    .mem_px_addr(mem_px_addr),
    .red_cnt    (red_cnt),
    .green_cnt  (green_cnt),
    .blue_cnt   (blue_cnt),
    .color      (color),
    .done       (done)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic prev_done = 1'b0;
  always @(negedge pclk) begin
    if (done === 1'b1) begin
      n_done++;
      check({cur, "_done_width"}, {31'd0, prev_done}, 0);
      check({cur, "_done_expected"}, (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        m_e = sb.pop_front();
        check({cur, "_red"}, red_cnt, m_e.r);
        check({cur, "_green"}, green_cnt, m_e.g);
        check({cur, "_blue"}, blue_cnt, m_e.b);
        check({cur, "_color"}, color, m_e.c);
      end
    end
    prev_done = done;
  end

  task automatic push_exp(input int r, input int g, input int b, input int c);
    exp_t e;
    e.r = AW'(r);
    e.g = AW'(g);
    e.b = AW'(b);
    e.c = 2'(c);
    sb.push_back(e);
  endtask

  task automatic start_frame();
    @(posedge pclk);
    #1;
    px_wr = 1'b0;
    vsync = 1'b1;
    repeat (3) @(posedge pclk);
    #1 vsync = 1'b0;
    repeat (2) @(posedge pclk);
  endtask

  task automatic send_px(input logic [7:0] p, input int n, input bit vs_last);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
      px_wr = 1'b1;
      mem_px_data = p;
      mem_px_addr = AW'(addr);
      addr++;
      if (vs_last && (i == n - 1)) vsync = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1 px_wr = 1'b0;
    end
  endtask

  // done must appear on the second falling edge after the frame-end edge
  task automatic end_frame();
    int lat;
    lat = 0;
    @(posedge pclk);
    #1;
    px_wr = 1'b0;
    vsync = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge pclk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({cur, "_latency"}, lat, 2);
  endtask

  task automatic run_frame(input frame_t f);
    start_frame();
    push_exp(f.er, f.eg, f.eb, f.ec);
    send_px(f.p0, f.n0, 1'b0);
    send_px(f.p1, f.n1, 1'b0);
    send_px(f.p2, f.n2, f.vend);
    end_frame();
  endtask

  initial begin
    int er, eg, eb, nd0;

    tbl[0] = '{19200, 8'hE0, 0, 8'h00, 0, 8'h00, 1'b0, 19200, 0, 0, 1};
    tbl[1] = '{10000, 8'h1C, 9200, 8'h03, 0, 8'h00, 1'b0, 0, 10000, 9200, 2};
    tbl[2] = '{500, 8'h03, 0, 8'h00, 1000, 8'h92, 1'b1, 0, 0, 500, 0};
    tbl[3] = '{1500, 8'hE0, 1500, 8'h03, 200, 8'h00, 1'b1, 1500, 0, 1500, 0};
    tbl[4] = '{0, 8'h00, 0, 8'h00, 999, 8'h1C, 1'b1, 0, 999, 0, 0};
    tbl[5] = '{0, 8'h00, 0, 8'h00, 1000, 8'h03, 1'b1, 0, 0, 1000, 3};
    tbl[6] = '{1000, 8'hE0, 0, 8'h00, 1001, 8'h1C, 1'b1, 1000, 1001, 0, 2};

    mix[0]  = '{8'hE0, 1, 50};
    mix[1]  = '{8'hAD, 1, 1100};
    mix[2]  = '{8'h8D, 0, 30};
    mix[3]  = '{8'h1C, 2, 40};
    mix[4]  = '{8'h75, 2, 60};
    mix[5]  = '{8'h76, 0, 20};
    mix[6]  = '{8'h03, 3, 35};
    mix[7]  = '{8'h6E, 3, 45};
    mix[8]  = '{8'h8E, 0, 25};
    mix[9]  = '{8'hAE, 0, 15};
    mix[10] = '{8'h92, 0, 10};
    mix[11] = '{8'hFF, 0, 12};

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_red", red_cnt, 0);
    check("rst_green", green_cnt, 0);
    check("rst_blue", blue_cnt, 0);
    check("rst_color", color, 0);
    check("rst_done", done, 0);
    @(posedge pclk);
    #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      cur = $sformatf("frame%0d", i);
      run_frame(tbl[i]);
    end

    // strobes while idle must not leak into the next frame
    cur = "mix";
    send_px(8'hE0, 20, 1'b0);
    er = 0;
    eg = 0;
    eb = 0;
    for (int i = 0; i < 12; i++) begin
      if (mix[i].cls == 1) er += mix[i].n;
      if (mix[i].cls == 2) eg += mix[i].n;
      if (mix[i].cls == 3) eb += mix[i].n;
    end
    start_frame();
    push_exp(er, eg, eb, 1);
    for (int i = 0; i < 12; i++) begin
      send_px(mix[i].p, mix[i].n, (i == 11));
      if (i != 11) idle(2);
    end
    end_frame();
    send_px(8'h03, 10, 1'b0);

    cur = "rst_mid";
    nd0 = n_done;
    start_frame();
    send_px(8'hE0, 5000, 1'b0);
    @(posedge pclk);
    #1 rst = 1'b1;
    @(posedge pclk);
    #1 rst = 1'b0;
    @(negedge pclk);
    check("rst_mid_red", red_cnt, 0);
    check("rst_mid_color", color, 0);
    check("rst_mid_done", done, 0);
    send_px(8'hE0, 100, 1'b0);
    idle(1);
    vsync = 1'b1;
    repeat (10) @(posedge pclk);
    check("rst_mid_no_done", n_done, nd0);

    cur = "after_rst";
    fb = '{19200, 8'h03, 0, 8'h00, 0, 8'h00, 1'b0, 0, 0, 19200, 3};
    run_frame(fb);
    repeat (3) @(posedge pclk);
    check("after_rst_single_done", n_done, nd0 + 1);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
